inst_encoder: RTL and testbench

Converts field-level instruction descriptions (operation index, register numbers, byte-valued immediate) into 32-bit LA32R instruction words and streams them into the instruction-memory write port at sequential word addresses. It runs the decoder's field mapping in reverse: immediates arrive in the same extended, byte-valued form the decoder produces, and the encoder range-checks them and packs them back into instruction fields. It is the program loader used by self-test and bring-up benches.

---
 rtl/inst_encoder.sv | 179 +++++++++++++++++
 tb/tb_inst_encoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// LA32R instruction encoder: packs field-level descriptors into 32-bit words and
// streams them to the instruction-memory write port at sequential word addresses.
module inst_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
   parameter int          DEPTH     = 1024,
   localparam int         CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_op,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rj,
   input  logic [4:0]       in_rk,
   input  logic [31:0]      in_imm,
   output logic             imem_we,
   input  logic             imem_wready,
   output logic [31:0]      imem_addr,
   output logic [31:0]      imem_wdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             err,
   output logic [5:0]       err_op
);

   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;

   state_t             state;
   logic signed [31:0] imm_s;
   logic [9:0]         rj_rd;
   logic [31:0]        enc_word;
   logic               enc_ok;
   logic               wr;
   logic               acc;
   logic               full_next;

   function automatic logic in_srange(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

   function automatic logic [31:0] opc_base(input logic [5:0] op);
      case (op)
         6'd0:    return 32'h0010_0000;
         6'd1:    return 32'h0011_0000;
         6'd2:    return 32'h0012_0000;
         6'd3:    return 32'h0012_8000;
         6'd4:    return 32'h0014_8000;
         6'd5:    return 32'h0015_0000;
         6'd6:    return 32'h0015_8000;
         6'd7:    return 32'h0017_0000;
         6'd8:    return 32'h0017_8000;
         6'd9:    return 32'h0018_0000;
         6'd10:   return 32'h0040_8000;
         6'd11:   return 32'h0044_8000;
         6'd12:   return 32'h0048_8000;
         6'd13:   return 32'h0200_0000;
         6'd14:   return 32'h0240_0000;
         6'd15:   return 32'h0280_0000;
         6'd16:   return 32'h0340_0000;
         6'd17:   return 32'h0380_0000;
         6'd18:   return 32'h03c0_0000;
         6'd19:   return 32'h1400_0000;
         6'd20:   return 32'h1c00_0000;
         6'd21:   return 32'h2800_0000;
         6'd22:   return 32'h2840_0000;
         6'd23:   return 32'h2880_0000;
         6'd24:   return 32'h2a00_0000;
         6'd25:   return 32'h2a40_0000;
         6'd26:   return 32'h2900_0000;
         6'd27:   return 32'h2940_0000;
         6'd28:   return 32'h2980_0000;
         6'd29:   return 32'h4c00_0000;
         6'd30:   return 32'h5000_0000;
         6'd31:   return 32'h5400_0000;
         6'd32:   return 32'h5800_0000;
         6'd33:   return 32'h5c00_0000;
         6'd34:   return 32'h6000_0000;
         6'd35:   return 32'h6400_0000;
         6'd36:   return 32'h6800_0000;
         6'd37:   return 32'h6c00_0000;
         default: return 32'h0;
      endcase
   endfunction

   assign imm_s = in_imm;
   assign rj_rd = {in_rj, in_rd};

   // Immediates arrive sign/zero-extended; check the range, then pack the field bits.
   always_comb begin
      enc_word = opc_base(in_op);
      enc_ok   = 1'b1;
      case (in_op) inside
         [6'd0:6'd9]: enc_word = enc_word | {17'd0, in_rk, rj_rd};
         [6'd10:6'd12]: begin
            enc_ok   = in_imm < 32'd32;
            enc_word = enc_word | {17'd0, in_imm[4:0], rj_rd};
         end
         [6'd13:6'd15], [6'd21:6'd28]: begin
            enc_ok   = in_srange(imm_s, -32'sd2048, 32'sd2047);
            enc_word = enc_word | {10'd0, in_imm[11:0], rj_rd};
         end
         [6'd16:6'd18]: begin
            enc_ok   = in_imm < 32'd4096;
            enc_word = enc_word | {10'd0, in_imm[11:0], rj_rd};
         end
         [6'd19:6'd20]: begin
            enc_ok   = in_imm[11:0] == 12'd0;
            enc_word = enc_word | {7'd0, in_imm[31:12], in_rd};
         end
         6'd29, [6'd32:6'd37]: begin
            enc_ok   = (in_imm[1:0] == 2'd0) && in_srange(imm_s, -32'sd131072, 32'sd131068);
            enc_word = enc_word | {6'd0, in_imm[17:2], rj_rd};
         end
         [6'd30:6'd31]: begin
            enc_ok   = (in_imm[1:0] == 2'd0) && in_srange(imm_s, -32'sd134217728, 32'sd134217724);
            enc_word = enc_word | {6'd0, in_imm[17:2], in_imm[27:18]};
         end
         default: begin
            enc_ok   = 1'b0;
            enc_word = 32'h0;
         end
      endcase
   end

   assign wr        = imem_we && imem_wready;
   assign full_next = imem_we && (count == LAST_C);
   assign in_ready  = !start && (state != DONE) && !full_next && (!imem_we || imem_wready);
   assign acc       = in_valid && in_ready;

   // Output register stage: one pending word, address/count advance on each completed write.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= 32'h0;
         count      <= '0;
         full       <= 1'b0;
         err        <= 1'b0;
         err_op     <= 6'd0;
      end else if (start) begin
         state     <= IDLE;
         imem_we   <= 1'b0;
         imem_addr <= BASE_ADDR;
         count     <= '0;
         full      <= 1'b0;
         err       <= 1'b0;
         err_op    <= 6'd0;
      end else begin
         if (wr) begin
            imem_addr <= imem_addr + 32'd4;
            count     <= count + CNT_W'(1);
         end
         if (wr && full_next) begin
            state   <= DONE;
            full    <= 1'b1;
            imem_we <= 1'b0;
         end else if (acc && enc_ok) begin
            state      <= PEND;
            imem_we    <= 1'b1;
            imem_wdata <= enc_word;
         end else if (wr) begin
            state   <= IDLE;
            imem_we <= 1'b0;
         end
         if (acc && !enc_ok) begin
            err <= 1'b1;
            if (!err) err_op <= in_op;
         end
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: a field-rule reference model queues expected
// writes on each accepted descriptor; a negedge monitor checks every presented word.
module tb_inst_encoder;

   localparam logic [31:0] BASE  = 32'h1c00_0000;
   localparam int          DEPTH = 4;
   localparam int          CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rstn, start, in_valid, in_ready, imem_we, imem_wready, full, err;
   logic [5:0]    in_op, err_op;
   logic [4:0]    in_rd, in_rj, in_rk;
   logic [31:0]   in_imm, imem_addr, imem_wdata;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rj(in_rj), .in_rk(in_rk), .in_imm(in_imm),
      .imem_we(imem_we), .imem_wready(imem_wready), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .count(count), .full(full), .err(err), .err_op(err_op)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t q[$];
   wr_t popped;
   int  n_vec = 0, n_fail = 0;
   int  cnt_m = 0, n_acc = 0, err_op_m = 0;
   bit  err_m = 0;

   logic [31:0] opc_tab [38] = '{
      32'h00100000, 32'h00110000, 32'h00120000, 32'h00128000, 32'h00148000,
      32'h00150000, 32'h00158000, 32'h00170000, 32'h00178000, 32'h00180000,
      32'h00408000, 32'h00448000, 32'h00488000, 32'h02000000, 32'h02400000,
      32'h02800000, 32'h03400000, 32'h03800000, 32'h03c00000, 32'h14000000,
      32'h1c000000, 32'h28000000, 32'h28400000, 32'h28800000, 32'h2a000000,
      32'h2a400000, 32'h29000000, 32'h29400000, 32'h29800000, 32'h4c000000,
      32'h50000000, 32'h54000000, 32'h58000000, 32'h5c000000, 32'h60000000,
      32'h64000000, 32'h68000000, 32'h6c000000};

   int edges [20] = '{0, 31, 32, -1, 2047, 2048, -2048, -2049, 4095, 4096,
                      131068, 131072, -131072, -131076, 134217724, 134217728,
                      -134217728, 32'h12345000, 8, 6};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoder: field values computed with plain integer arithmetic.
   function automatic bit ref_enc(input int op, input int rd, input int rj, input int rk,
                                  input logic [31:0] imm, output logic [31:0] w);
      longint s, b, f;
      bit ok;
      w = 32'h0;
      if (op > 37) return 1'b0;
      s  = longint'($signed(imm));
      b  = longint'(opc_tab[op]);
      ok = 1'b1;
      if (op <= 9) begin
         w = 32'(b + rk * 1024 + rj * 32 + rd);
      end else if (op <= 12) begin
         ok = s >= 0 && s <= 31;
         w  = 32'(b + s * 1024 + rj * 32 + rd);
      end else if (op <= 15 || (op >= 21 && op <= 28)) begin
         ok = s >= -2048 && s <= 2047;
         f  = ((s % 4096) + 4096) % 4096;
         w  = 32'(b + f * 1024 + rj * 32 + rd);
      end else if (op <= 18) begin
         ok = s >= 0 && s <= 4095;
         w  = 32'(b + s * 1024 + rj * 32 + rd);
      end else if (op <= 20) begin
         ok = (s % 4096) == 0;
         f  = (((s / 4096) % 1048576) + 1048576) % 1048576;
         w  = 32'(b + f * 32 + rd);
      end else if (op == 30 || op == 31) begin
         ok = (s % 4) == 0 && s >= -134217728 && s <= 134217724;
         f  = (((s / 4) % 67108864) + 67108864) % 67108864;
         w  = 32'(b + (f % 65536) * 1024 + f / 65536);
      end else begin
         ok = (s % 4) == 0 && s >= -131072 && s <= 131068;
         f  = (((s / 4) % 65536) + 65536) % 65536;
         w  = 32'(b + f * 1024 + rj * 32 + rd);
      end
      return ok;
   endfunction

   function automatic logic [31:0] gen_imm(input int op);
      int t;
      case ($urandom_range(0, 4))
         0: t = int'($urandom_range(0, 31));
         1: t = int'($urandom_range(0, 4095)) - 2048;
         2: t = edges[$urandom_range(0, 19)];
         3: t = int'($urandom & 32'hFFFFF000);
         default: begin
            if (op == 30 || op == 31) t = (int'($urandom_range(0, 67108863)) - 33554432) * 4;
            else                      t = (int'($urandom_range(0, 65535)) - 32768) * 4;
         end
      endcase
      return t;
   endfunction

   task automatic model_reset();
      q.delete();
      cnt_m    = 0;
      n_acc    = 0;
      err_m    = 0;
      err_op_m = 0;
   endtask

   // Monitor: every word presented must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rstn) begin
         chk("count", 32'(count), cnt_m);
         chk("full", full, cnt_m == DEPTH);
         chk("err", err, err_m);
         chk("err_op", err_op, err_op_m);
         chk("imem_we", imem_we, q.size() != 0);
         if (imem_we && q.size() != 0) begin
            chk("imem_addr", imem_addr, q[0].addr);
            chk("imem_wdata", imem_wdata, q[0].data);
            if (imem_wready && !start) begin
               popped = q.pop_front();
               cnt_m++;
            end
         end
      end
   end

   task automatic book(output bit acc);
      bit          exp_rdy, ok;
      logic [31:0] w;
      wr_t         e;
      exp_rdy = !start && (cnt_m + q.size() < DEPTH) && !(q.size() != 0 && !imem_wready);
      chk("in_ready", in_ready, exp_rdy);
      acc = in_valid && in_ready;
      if (start) begin
         model_reset();
      end else if (acc) begin
         ok = ref_enc(int'(in_op), int'(in_rd), int'(in_rj), int'(in_rk), in_imm, w);
         if (ok) begin
            e.addr = BASE + 32'(4 * n_acc);
            e.data = w;
            q.push_back(e);
            n_acc++;
         end else begin
            if (!err_m) err_op_m = int'(in_op);
            err_m = 1;
         end
      end
   endtask

   task automatic step(input bit v, input int op, input int rd, input int rj, input int rk,
                       input logic [31:0] imm, input bit wr, input bit st, output bit acc);
      @(posedge clk);
      #1;
      in_valid    = v;
      in_op       = 6'(op);
      in_rd       = 5'(rd);
      in_rj       = 5'(rj);
      in_rk       = 5'(rk);
      in_imm      = imm;
      imem_wready = wr;
      start       = st;
      @(negedge clk);
      #1;
      book(acc);
   endtask

   initial begin
      bit a;
      int n;
      rstn = 0; start = 0; in_valid = 0; in_op = 0; in_rd = 0; in_rj = 0; in_rk = 0;
      in_imm = 0; imem_wready = 0;
      repeat (3) @(posedge clk);
      #1 rstn = 1;
      model_reset();
      @(negedge clk);
      #1;
      chk("rst_we", imem_we, 0);
      chk("rst_addr", imem_addr, BASE);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ready", in_ready, 1);

      // ADD_W r3, r1, r2
      step(1, 0, 3, 1, 2, 0, 1, 0, a);
      step(0, 0, 0, 0, 0, 0, 1, 0, a);
      chk("add_we", imem_we, 1);
      chk("add_addr", imem_addr, BASE);
      chk("add_data", imem_wdata, 32'h00100823);

      // ADDI_W -2048 then LU12I_W back to back
      step(0, 0, 0, 0, 0, 0, 1, 1, a);
      step(1, 15, 5, 0, 0, 32'hFFFFF800, 1, 0, a);
      step(1, 19, 4, 0, 0, 32'h12345000, 1, 0, a);
      chk("addi_acc2", a, 1);
      chk("addi_data", imem_wdata, 32'h02a00005);
      chk("addi_addr", imem_addr, BASE);
      step(0, 0, 0, 0, 0, 0, 1, 0, a);
      chk("lu12i_data", imem_wdata, 32'h142468a4);
      chk("lu12i_addr", imem_addr, BASE + 32'd4);

      // BEQ then B with a 3-cycle memory stall
      step(0, 0, 0, 0, 0, 0, 1, 1, a);
      step(1, 32, 2, 1, 0, 32'd8, 0, 0, a);
      for (int i = 0; i < 3; i++) begin
         step(1, 30, 7, 9, 3, 32'hFFFFFFFC, 0, 0, a);
         chk("hold_acc", a, 0);
         chk("hold_data", imem_wdata, 32'h58000822);
         chk("hold_addr", imem_addr, BASE);
      end
      step(1, 30, 7, 9, 3, 32'hFFFFFFFC, 1, 0, a);
      chk("b_acc", a, 1);
      step(0, 0, 0, 0, 0, 0, 1, 0, a);
      chk("b_data", imem_wdata, 32'h53ffffff);
      chk("b_addr", imem_addr, BASE + 32'd4);

      // Out-of-range immediates are rejected
      step(0, 0, 0, 0, 0, 0, 1, 1, a);
      step(1, 15, 1, 1, 0, 32'd2048, 1, 0, a);
      step(1, 10, 1, 1, 0, 32'd32, 1, 0, a);
      step(0, 0, 0, 0, 0, 0, 1, 0, a);
      chk("rej_err", err, 1);
      chk("rej_err_op", err_op, 15);
      chk("rej_count", 32'(count), 0);
      chk("rej_addr", imem_addr, BASE);
      chk("rej_we", imem_we, 0);

      // Fill to DEPTH, then restart
      step(0, 0, 0, 0, 0, 0, 1, 1, a);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         step(1, 0, i + 1, 2, 3, 0, 1, 0, a);
         n += int'(a);
      end
      step(0, 0, 0, 0, 0, 0, 1, 0, a);
      step(0, 0, 0, 0, 0, 0, 1, 0, a);
      chk("fill_acc", n, DEPTH);
      chk("fill_count", 32'(count), DEPTH);
      chk("fill_full", full, 1);
      chk("fill_ready", in_ready, 0);
      step(0, 0, 0, 0, 0, 0, 1, 1, a);
      step(0, 0, 0, 0, 0, 0, 1, 0, a);
      chk("restart_count", 32'(count), 0);
      chk("restart_full", full, 0);
      step(1, 5, 1, 2, 3, 0, 1, 0, a);
      step(0, 0, 0, 0, 0, 0, 1, 0, a);
      chk("restart_addr", imem_addr, BASE);

      // Asynchronous reset while a write is pending
      step(1, 10, 1, 1, 0, 32'd40, 1, 0, a);
      step(1, 0, 3, 1, 2, 0, 0, 0, a);
      @(posedge clk);
      #1 in_valid = 0;
      chk("pre_rst_we", imem_we, 1);
      #2 rstn = 0;
      #1;
      chk("arst_we", imem_we, 0);
      chk("arst_addr", imem_addr, BASE);
      chk("arst_wdata", imem_wdata, 0);
      chk("arst_count", 32'(count), 0);
      chk("arst_full", full, 0);
      chk("arst_err", err, 0);
      chk("arst_err_op", err_op, 0);
      @(posedge clk);
      #1 rstn = 1;
      model_reset();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         int op;
         op = int'($urandom_range(0, 45));
         step($urandom_range(0, 3) != 0, op, int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), gen_imm(op),
              $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, a);
      end
      repeat (4) step(0, 0, 0, 0, 0, 0, 1, 0, a);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
